mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares the processor's one synchronous 32-bit instruction/data memory among three requesters: host loader/debug port (H), instruction fetch (F) and data load/store (D). It sits between the controller/datapath and the memory block. It issues at most one memory command per cycle and returns read data one cycle later to the granted requester. It provides host preemption, F/D round-robin fairness and a D-side lock for atomic read-modify-write sequences.

## Interface
- AW, 16, address width
- DW, 32, data width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- h_req, f_req, d_req  in  1 each  access request
- h_we, d_we  in  1 each  1 = write, 0 = read; F is read-only
- h_addr, f_addr, d_addr  in  AW each  word address
- h_wdata, d_wdata  in  DW each  write data
- d_lock  in  1  keep the arbiter locked to D after this access
- h_gnt, f_gnt, d_gnt  out  1 each  combinational grant, one-hot or zero
- h_rvalid, f_rvalid, d_rvalid  out  1 each  registered read-data-valid
- rdata  out  DW  shared read data, equals mem_rdata
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after the read command
- locked  out  1  state == LOCKED

## Operation
- State machine has two states, IDLE and LOCKED. A second register, rr_ptr (0 = F preferred, 1 = D preferred), holds the round-robin pointer.
- Grant in IDLE:
  - If h_req, grant H.
  - Otherwise, if only one of f_req and d_req is set, grant it.
  - Otherwise, if both are set, grant the side selected by rr_ptr.
- Grant in LOCKED: only D can be granted. H and F requests wait with gnt = 0.
- rr_ptr update: a grant to F sets rr_ptr = 1, and a grant to D sets rr_ptr = 0. An H grant leaves rr_ptr unchanged.
- Transitions:
  - IDLE -> LOCKED on a D grant with d_lock = 1.
  - LOCKED -> IDLE on a D grant with d_lock = 0.
  - LOCKED with no d_req stays LOCKED indefinitely.
- Memory drive:
  - mem_en = OR of grants. mem_we = we of the granted requester; 0 for F.
  - mem_addr and mem_wdata are muxed from the granted requester.
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Read return: a read grant in cycle N sets the matching X_rvalid to 1 in cycle N+1 for one cycle only. Writes never produce rvalid.
- Requesters hold req/we/addr/wdata stable until they see gnt = 1 in a cycle. The access completes at the clock edge ending that cycle. A requester may drop or re-present req in the next cycle.
- Only the arbiter's grant order and state are registered. No request data is buffered.

## Timing
- Reset values:
  - State = IDLE, rr_ptr = 0, all rvalid = 0.
  - During reset cycles, all gnt = 0 and mem_en = 0.
  - rdata follows mem_rdata.
- Latency: the grant is in the same cycle as the request, provided the request wins arbitration. Read data arrives 1 cycle after the grant.
- Throughput: 1 access per cycle. Back-to-back reads from different requesters in cycles N and N+1 give rvalid for the first in N+1 and for the second in N+2.
- Request and its own rvalid in the same cycle (N+1): legal. The rvalid refers to the cycle-N access.
- Reset asserted in cycle N+1 after a read grant in cycle N: rvalid is forced to 0 and the read is dropped. A lock held at reset is released.
- d_lock is sampled only in a cycle where d_gnt = 1.
- Address arithmetic: none, addresses pass through unchanged, no wrap handling.

## Test plan
- F alone reads addr 0x0003, memory returns 0x01020304 -> f_gnt = 1 in cycle 0, f_rvalid = 1 with rdata 0x01020304 in cycle 1, mem_we = 0.
- F and D request continuously (reads) after reset -> grants alternate F, D, F, D. Each rvalid lands exactly one cycle after its grant.
- H write 0xDEADBEEF to 0x0010 while F and D also request -> h_gnt = 1, mem_we = 1, mem_addr = 0x0010; no h_rvalid follows; F is served next (rr_ptr still 0).
- D reads 0x0020 with d_lock = 1, then H and F request for 3 cycles while D is idle, then D writes 0x0020 with d_lock = 0:
  - locked = 1 throughout those cycles, h_gnt = 0 and f_gnt = 0.
  - After the D write, locked = 0 and H is granted in the next cycle.
- F read granted in cycle 5, reset high in cycle 6 -> f_rvalid = 0 in cycle 6, state = IDLE, rr_ptr = 0, no grants in cycle 6.
- No requests -> mem_en = 0, mem_addr = 0x0000, all rvalid = 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/grant/memory bundle for mem_arbiter: three requesters on one side,
// one synchronous single-port memory on the other.
interface mem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic          h_req, f_req, d_req;
    logic          h_we, d_we;
    logic [AW-1:0] h_addr, f_addr, d_addr;
    logic [DW-1:0] h_wdata, d_wdata;
    logic          d_lock;
    logic          h_gnt, f_gnt, d_gnt;
    logic          h_rvalid, f_rvalid, d_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          locked;

    // Arbiter side
    modport slave (
        input  h_req, f_req, d_req, h_we, d_we, h_addr, f_addr, d_addr,
        input  h_wdata, d_wdata, d_lock, mem_rdata,
        output h_gnt, f_gnt, d_gnt, h_rvalid, f_rvalid, d_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, locked
    );

    // Requester/memory side
    modport master (
        output h_req, f_req, d_req, h_we, d_we, h_addr, f_addr, d_addr,
        output h_wdata, d_wdata, d_lock, mem_rdata,
        input  h_gnt, f_gnt, d_gnt, h_rvalid, f_rvalid, d_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, locked
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: host preempts, F/D share round-robin, D may lock
// the port across a read-modify-write. Read data returns one cycle after grant.
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e state_q;
    logic   rr_ptr_q;
    logic   h_rvalid_q, f_rvalid_q, d_rvalid_q;
    logic   h_gnt, f_gnt, d_gnt;

    // Grants are forced low during reset so no command reaches memory.
    always_comb begin
        h_gnt = 1'b0;
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state_q == StLocked) begin
                d_gnt = bus.d_req;
            end else if (bus.h_req) begin
                h_gnt = 1'b1;
            end else if (bus.f_req && bus.d_req) begin
                if (rr_ptr_q) d_gnt = 1'b1;
                else          f_gnt = 1'b1;
            end else begin
                f_gnt = bus.f_req;
                d_gnt = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= 1'b0;
            h_rvalid_q <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            h_rvalid_q <= h_gnt & ~bus.h_we;
            f_rvalid_q <= f_gnt;
            d_rvalid_q <= d_gnt & ~bus.d_we;
            if (f_gnt)      rr_ptr_q <= 1'b1;
            else if (d_gnt) rr_ptr_q <= 1'b0;
            if (d_gnt) state_q <= bus.d_lock ? StLocked : StIdle;
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (h_gnt) begin
            bus.mem_addr  = bus.h_addr;
            bus.mem_wdata = bus.h_wdata;
        end else if (f_gnt) begin
            bus.mem_addr  = bus.f_addr;
        end else if (d_gnt) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    assign bus.h_gnt  = h_gnt;
    assign bus.f_gnt  = f_gnt;
    assign bus.d_gnt  = d_gnt;
    assign bus.mem_en = h_gnt | f_gnt | d_gnt;
    assign bus.mem_we = (h_gnt & bus.h_we) | (d_gnt & bus.d_we);

    // A read granted just before reset is dropped in the reset cycle itself.
    assign bus.h_rvalid = h_rvalid_q & ~reset;
    assign bus.f_rvalid = f_rvalid_q & ~reset;
    assign bus.d_rvalid = d_rvalid_q & ~reset;
    assign bus.rdata    = bus.mem_rdata;
    assign bus.locked   = (state_q == StLocked);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory behind it.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if #(.AW(16), .DW(32)) bus ();

    mem_arbiter dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory contents on reset: word i holds 0xA0000000 | i, word 3 is special.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
            mem[3] <= 32'h0102_0304;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.h_req = 0; bus.f_req = 0; bus.d_req = 0;
        bus.h_we = 0; bus.d_we = 0; bus.d_lock = 0;
        bus.h_addr = '0; bus.f_addr = '0; bus.d_addr = '0;
        bus.h_wdata = '0; bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        idle_reqs();
        reset = 1;
        adv();
        reset = 0;
    endtask

    initial begin
        bus.mem_rdata = '0;
        idle_reqs();
        reset = 1;
        bus.f_req = 1;
        settle();
        chk("rst_f_gnt", bus.f_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_rvalid", {bus.h_rvalid, bus.f_rvalid, bus.d_rvalid}, 0);
        chk("rst_locked", bus.locked, 0);
        adv();
        bus.f_req = 0;
        adv();
        reset = 0;

        // No requests
        settle();
        chk("idle_mem_en", bus.mem_en, 0);
        chk("idle_addr", bus.mem_addr, 16'h0000);
        chk("idle_rvalid", {bus.h_rvalid, bus.f_rvalid, bus.d_rvalid}, 0);
        adv();

        // F alone reads 0x0003
        bus.f_req = 1; bus.f_addr = 16'h0003;
        settle();
        chk("f_gnt", bus.f_gnt, 1);
        chk("f_mem_we", bus.mem_we, 0);
        chk("f_mem_addr", bus.mem_addr, 16'h0003);
        adv();
        bus.f_req = 0;
        settle();
        chk("f_rvalid", bus.f_rvalid, 1);
        chk("f_rdata", bus.rdata, 32'h0102_0304);
        adv();
        settle();
        chk("f_rvalid_once", bus.f_rvalid, 0);
        adv();

        // F and D both read continuously: F, D, F, D
        do_reset();
        bus.f_req = 1; bus.f_addr = 16'h0001;
        bus.d_req = 1; bus.d_addr = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("rr_f_gnt%0d", i), bus.f_gnt, (i % 2 == 0));
            chk($sformatf("rr_d_gnt%0d", i), bus.d_gnt, (i % 2 == 1));
            chk($sformatf("rr_f_rv%0d", i), bus.f_rvalid, (i % 2 == 1));
            chk($sformatf("rr_d_rv%0d", i), bus.d_rvalid, (i >= 2) && (i % 2 == 0));
            if (i > 0)
                chk($sformatf("rr_rdata%0d", i), bus.rdata,
                    (i % 2 == 1) ? 32'hA000_0001 : 32'hA000_0002);
            adv();
        end
        bus.f_req = 0; bus.d_req = 0;
        settle();
        chk("rr_d_rv_last", bus.d_rvalid, 1);
        chk("rr_rdata_last", bus.rdata, 32'hA000_0002);
        adv();

        // H write preempts; F is next, then D
        do_reset();
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 16'h0010; bus.h_wdata = 32'hDEAD_BEEF;
        bus.f_req = 1; bus.f_addr = 16'h0010;
        bus.d_req = 1; bus.d_addr = 16'h0002;
        settle();
        chk("h_gnt", bus.h_gnt, 1);
        chk("h_fd_gnt", {bus.f_gnt, bus.d_gnt}, 0);
        chk("h_mem_we", bus.mem_we, 1);
        chk("h_mem_addr", bus.mem_addr, 16'h0010);
        chk("h_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        adv();
        bus.h_req = 0; bus.h_we = 0;
        settle();
        chk("h_no_rvalid", bus.h_rvalid, 0);
        chk("h_then_f", bus.f_gnt, 1);
        adv();
        bus.f_req = 0;
        settle();
        chk("h_wr_readback", bus.rdata, 32'hDEAD_BEEF);
        chk("h_then_d", bus.d_gnt, 1);
        adv();
        idle_reqs();

        // D locked read-modify-write
        do_reset();
        bus.d_req = 1; bus.d_addr = 16'h0020; bus.d_lock = 1;
        settle();
        chk("lk_d_gnt", bus.d_gnt, 1);
        chk("lk_pre_locked", bus.locked, 0);
        adv();
        bus.d_req = 0; bus.d_lock = 0;
        bus.h_req = 1; bus.h_addr = 16'h0005;
        bus.f_req = 1; bus.f_addr = 16'h0006;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("lk_locked%0d", i), bus.locked, 1);
            chk($sformatf("lk_hf_gnt%0d", i), {bus.h_gnt, bus.f_gnt}, 0);
            chk($sformatf("lk_mem_en%0d", i), bus.mem_en, 0);
            if (i == 0) chk("lk_rdata", bus.rdata, 32'hA000_0020);
            adv();
        end
        bus.d_req = 1; bus.d_we = 1; bus.d_wdata = 32'h5555_AAAA; bus.d_lock = 0;
        settle();
        chk("lk_wr_gnt", {bus.h_gnt, bus.f_gnt, bus.d_gnt}, 3'b001);
        chk("lk_wr_we", bus.mem_we, 1);
        chk("lk_wr_locked", bus.locked, 1);
        adv();
        bus.d_req = 0; bus.d_we = 0;
        settle();
        chk("unlk_locked", bus.locked, 0);
        chk("unlk_h_gnt", bus.h_gnt, 1);
        chk("unlk_d_rvalid", bus.d_rvalid, 0);
        adv();

        // Lock released by reset
        do_reset();
        bus.d_req = 1; bus.d_lock = 1;
        adv();
        do_reset();
        bus.h_req = 1;
        settle();
        chk("rstlk_locked", bus.locked, 0);
        chk("rstlk_h_gnt", bus.h_gnt, 1);
        adv();

        // Reset right after an F read grant drops the read
        do_reset();
        for (int i = 0; i < 5; i++) adv();
        bus.f_req = 1; bus.f_addr = 16'h0003;
        settle();
        chk("rf_f_gnt", bus.f_gnt, 1);
        adv();
        reset = 1;
        bus.d_req = 1; bus.d_addr = 16'h0002;
        settle();
        chk("rf_f_rvalid", bus.f_rvalid, 0);
        chk("rf_gnts", {bus.h_gnt, bus.f_gnt, bus.d_gnt}, 0);
        chk("rf_mem_en", bus.mem_en, 0);
        adv();
        reset = 0;
        settle();
        chk("rf_rr_f_first", bus.f_gnt, 1);
        chk("rf_dropped", bus.f_rvalid, 0);
        adv();
        idle_reqs();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
